// File: rtl/commit_unit.sv
// ---------------------------------------------------------------------------
// commit_unit
//
// Reorder-buffer commit stage. Rename allocates entries at the tail,
// execution units mark entries complete via the writeback ports, and up to
// RETIRE_WIDTH completed entries retire in order from the head each cycle.
// An entry that completes with an exception raises a one-cycle flush pulse
// when it reaches the head. The buffer then spends one cycle in FLUSH,
// where it is emptied and ignores all traffic.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   alloc_*         allocation request / grant and the granted index (tail)
//   wb_*            per-port completion strobe, index, result and exception
//   ret_*           per-lane retire strobe, dest preg, value and ROB index
//   flush*          exception flush pulse and the faulting index
//   count           number of occupied entries (0..ROB_DEPTH)
// ---------------------------------------------------------------------------
module commit_unit #(
  parameter int ROB_DEPTH    = 16,
  parameter int RETIRE_WIDTH = 2,
  parameter int WB_PORTS     = 2,
  parameter int DATA_WIDTH   = 32,
  parameter int PREG_W       = 6,
  localparam int IDX_W       = $clog2(ROB_DEPTH)
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    alloc_valid,
  input  logic [PREG_W-1:0]                       alloc_dest,
  output logic                                    alloc_ready,
  output logic [IDX_W-1:0]                        alloc_rob_addr,
  input  logic [WB_PORTS-1:0]                     wb_valid,
  input  logic [WB_PORTS-1:0][IDX_W-1:0]          wb_rob_addr,
  input  logic [WB_PORTS-1:0][DATA_WIDTH-1:0]     wb_value,
  input  logic [WB_PORTS-1:0]                     wb_exc,
  output logic [RETIRE_WIDTH-1:0]                 ret_valid,
  output logic [RETIRE_WIDTH-1:0][PREG_W-1:0]     ret_dest,
  output logic [RETIRE_WIDTH-1:0][DATA_WIDTH-1:0] ret_value,
  output logic [RETIRE_WIDTH-1:0][IDX_W-1:0]      ret_rob_addr,
  output logic                                    flush,
  output logic [IDX_W-1:0]                        flush_rob_addr,
  output logic [IDX_W:0]                          count
);

  typedef enum logic {RUN, FLUSH} state_e;

  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  state_e state_q, state_d;

  // Head/tail carry an extra wrap bit so full and empty are distinguishable.
  logic [IDX_W:0] head_q, head_d;
  logic [IDX_W:0] tail_q, tail_d;
  logic [IDX_W:0] count_q, count_d;

  logic [ROB_DEPTH-1:0]                 valid_q, valid_d;
  logic [ROB_DEPTH-1:0]                 done_q, done_d;
  logic [ROB_DEPTH-1:0]                 exc_q, exc_d;
  logic [ROB_DEPTH-1:0][PREG_W-1:0]     dest_q, dest_d;
  logic [ROB_DEPTH-1:0][DATA_WIDTH-1:0] value_q, value_d;

  logic [IDX_W-1:0] headIdx;
  logic [IDX_W-1:0] tailIdx;
  logic             isFull;
  logic             allocFire;
  logic [IDX_W:0]   retireCnt;
  logic [IDX_W-1:0] laneIdx;
  logic             laneOk;

  assign headIdx = head_q[IDX_W-1:0];
  assign tailIdx = tail_q[IDX_W-1:0];
  assign isFull  = (headIdx == tailIdx) && (head_q[IDX_W] != tail_q[IDX_W]);

  assign alloc_ready    = !rst && !isFull && (state_q == RUN);
  assign alloc_rob_addr = tailIdx;
  assign allocFire      = alloc_valid && alloc_ready;
  assign count          = count_q;

  // An excepting head entry blocks lane 0, so nothing retires in the
  // flush cycle without any extra gating.
  assign flush = !rst && (state_q == RUN) && valid_q[headIdx] &&
                 done_q[headIdx] && exc_q[headIdx];
  assign flush_rob_addr = headIdx;

  // Retire lanes look only at registered state. Each lane also needs every
  // older lane to retire, which keeps retirement strictly in order and
  // stops it just before an excepting entry.
  always_comb begin
    ret_valid    = '0;
    ret_dest     = '0;
    ret_value    = '0;
    ret_rob_addr = '0;
    retireCnt    = '0;
    laneOk       = 1'b1;
    laneIdx      = '0;
    for (int k = 0; k < RETIRE_WIDTH; k++) begin
      laneIdx         = headIdx + IDX_W'(k);
      ret_rob_addr[k] = laneIdx;
      ret_dest[k]     = dest_q[laneIdx];
      ret_value[k]    = value_q[laneIdx];
      laneOk          = laneOk && valid_q[laneIdx] && done_q[laneIdx] && !exc_q[laneIdx];
      ret_valid[k]    = laneOk && (state_q == RUN) && !rst;
      if (ret_valid[k]) retireCnt = retireCnt + PTR_ONE;
    end
  end

  // Next-state logic for the FSM, pointers and entry storage.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    exc_d   = exc_q;
    dest_d  = dest_q;
    value_d = value_q;

    case (state_q)
      RUN: begin
        for (int k = 0; k < RETIRE_WIDTH; k++) begin
          if (ret_valid[k]) valid_d[headIdx + IDX_W'(k)] = 1'b0;
        end
        head_d = head_q + retireCnt;

        // Later ports overwrite earlier ones, so the highest port wins a
        // same-entry collision.
        for (int p = 0; p < WB_PORTS; p++) begin
          if (wb_valid[p] && valid_q[wb_rob_addr[p]]) begin
            done_d[wb_rob_addr[p]]  = 1'b1;
            value_d[wb_rob_addr[p]] = wb_value[p];
            exc_d[wb_rob_addr[p]]   = wb_exc[p];
          end
        end

        // Allocation never targets a valid entry (buffer is not full), so
        // it cannot collide with a writeback or a retirement.
        if (allocFire) begin
          valid_d[tailIdx] = 1'b1;
          done_d[tailIdx]  = 1'b0;
          exc_d[tailIdx]   = 1'b0;
          dest_d[tailIdx]  = alloc_dest;
          tail_d           = tail_q + PTR_ONE;
        end
        count_d = count_q + (allocFire ? PTR_ONE : '0) - retireCnt;

        if (flush) begin
          state_d = FLUSH;
          valid_d = '0;
          head_d  = '0;
          tail_d  = '0;
          count_d = '0;
        end
      end
      FLUSH: begin
        state_d = RUN;
        valid_d = '0;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
      default: state_d = RUN;
    endcase
  end

  // Control state is reset; the payload fields are always qualified by
  // valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    done_q  <= done_d;
    exc_q   <= exc_d;
    dest_q  <= dest_d;
    value_q <= value_d;
  end

endmodule

// File: tb/tb_commit_unit.sv
// ---------------------------------------------------------------------------
// tb_commit_unit
//
// Directed bench for commit_unit with default parameters. Expected
// retirements and flushes are queued as stimulus is issued; a negedge
// monitor pops them whenever the DUT asserts ret_valid or flush. Cycle-exact
// checks of count/alloc_ready/ret_valid are made from the stimulus process.
// ---------------------------------------------------------------------------
module tb_commit_unit;

  logic             clk = 1'b0;
  logic             rst;
  logic             alloc_valid;
  logic [5:0]       alloc_dest;
  logic             alloc_ready;
  logic [3:0]       alloc_rob_addr;
  logic [1:0]       wb_valid;
  logic [1:0][3:0]  wb_rob_addr;
  logic [1:0][31:0] wb_value;
  logic [1:0]       wb_exc;
  logic [1:0]       ret_valid;
  logic [1:0][5:0]  ret_dest;
  logic [1:0][31:0] ret_value;
  logic [1:0][3:0]  ret_rob_addr;
  logic             flush;
  logic [3:0]       flush_rob_addr;
  logic [4:0]       count;

  typedef struct packed {
    logic [3:0]  rob;
    logic [5:0]  dest;
    logic [31:0] value;
  } retExp_t;

  retExp_t    retQ[$];
  logic [3:0] flushQ[$];

  int cmpCount  = 0;
  int failCount = 0;

  commit_unit dut (
    .clk            (clk),
    .rst            (rst),
    .alloc_valid    (alloc_valid),
    .alloc_dest     (alloc_dest),
    .alloc_ready    (alloc_ready),
    .alloc_rob_addr (alloc_rob_addr),
    .wb_valid       (wb_valid),
    .wb_rob_addr    (wb_rob_addr),
    .wb_value       (wb_value),
    .wb_exc         (wb_exc),
    .ret_valid      (ret_valid),
    .ret_dest       (ret_dest),
    .ret_value      (ret_value),
    .ret_rob_addr   (ret_rob_addr),
    .flush          (flush),
    .flush_rob_addr (flush_rob_addr),
    .count          (count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmpCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; strobes are cleared just after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    alloc_valid = 1'b0;
    wb_valid    = '0;
    wb_exc      = '0;
  endtask

  task automatic applyStimulus(input logic doAlloc, input logic [5:0] dest,
                               input logic [1:0] wbV,
                               input logic [3:0] a0, input logic [31:0] v0, input logic e0,
                               input logic [3:0] a1, input logic [31:0] v1, input logic e1);
    alloc_valid    = doAlloc;
    alloc_dest     = dest;
    wb_valid       = wbV;
    wb_rob_addr[0] = a0;
    wb_value[0]    = v0;
    wb_exc[0]      = e0;
    wb_rob_addr[1] = a1;
    wb_value[1]    = v1;
    wb_exc[1]      = e1;
    tick();
  endtask

  task automatic allocOne(input logic [5:0] dest);
    applyStimulus(1'b1, dest, 2'b00, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0);
  endtask

  task automatic pushRet(input logic [3:0] rob, input logic [5:0] dest, input logic [31:0] value);
    retExp_t e;
    e.rob   = rob;
    e.dest  = dest;
    e.value = value;
    retQ.push_back(e);
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard monitor: every retiring lane and every flush pulse must
  // match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    retExp_t e;
    for (int k = 0; k < 2; k++) begin
      if (ret_valid[k]) begin
        if (retQ.size() == 0) begin
          cmpCount++;
          failCount++;
          $display("[TB] FAIL unexpected_retire lane%0d: got rob %0d, expected no retirement", k, ret_rob_addr[k]);
        end else begin
          e = retQ.pop_front();
          checkOutput($sformatf("ret_rob_lane%0d", k), 32'(ret_rob_addr[k]), 32'(e.rob));
          checkOutput($sformatf("ret_dest_lane%0d", k), 32'(ret_dest[k]), 32'(e.dest));
          checkOutput($sformatf("ret_value_lane%0d", k), ret_value[k], e.value);
        end
      end
    end
    if (flush) begin
      if (flushQ.size() == 0) begin
        cmpCount++;
        failCount++;
        $display("[TB] FAIL unexpected_flush: got rob %0d, expected no flush", flush_rob_addr);
      end else begin
        checkOutput("flush_rob_addr", 32'(flush_rob_addr), 32'(flushQ.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin : stimulus
    rst         = 1'b1;
    alloc_valid = 1'b0;
    alloc_dest  = '0;
    wb_valid    = '0;
    wb_rob_addr = '0;
    wb_value    = '0;
    wb_exc      = '0;

    // Reset: outputs held quiet while rst is high.
    tick();
    tick();
    checkOutput("rst_alloc_ready", 32'(alloc_ready), 32'd0);
    checkOutput("rst_ret_valid", 32'(ret_valid), 32'd0);
    checkOutput("rst_flush", 32'(flush), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_alloc_ready", 32'(alloc_ready), 32'd1);
    checkOutput("post_rst_alloc_addr", 32'(alloc_rob_addr), 32'd0);

    // Scenario 1: out-of-order completion, in-order retirement.
    allocOne(6'd10);
    allocOne(6'd11);
    allocOne(6'd12);
    checkOutput("s1_count_after_alloc", 32'(count), 32'd3);
    checkOutput("s1_alloc_addr", 32'(alloc_rob_addr), 32'd3);
    pushRet(4'd0, 6'd10, 32'hA0);
    pushRet(4'd1, 6'd11, 32'hA1);
    pushRet(4'd2, 6'd12, 32'hA2);
    applyStimulus(1'b0, 6'd0, 2'b01, 4'd2, 32'hA2, 1'b0, 4'd0, 32'd0, 1'b0);
    checkOutput("s1_no_retire_early", 32'(ret_valid), 32'd0);
    applyStimulus(1'b0, 6'd0, 2'b11, 4'd0, 32'hA0, 1'b0, 4'd1, 32'hA1, 1'b0);
    checkOutput("s1_ret_both", 32'(ret_valid), 32'b11);
    checkOutput("s1_count3", 32'(count), 32'd3);
    tick();
    checkOutput("s1_ret_one", 32'(ret_valid), 32'b01);
    checkOutput("s1_count1", 32'(count), 32'd1);
    tick();
    checkOutput("s1_ret_none", 32'(ret_valid), 32'd0);
    checkOutput("s1_count0", 32'(count), 32'd0);

    // Scenario 2: fill, drop overflow, then reuse the wrapped slot 0.
    doReset();
    for (int i = 0; i < 16; i++) allocOne(6'(20 + i));
    checkOutput("s2_full_count", 32'(count), 32'd16);
    checkOutput("s2_full_ready", 32'(alloc_ready), 32'd0);
    checkOutput("s2_full_tail", 32'(alloc_rob_addr), 32'd0);
    allocOne(6'd63);
    checkOutput("s2_drop_count", 32'(count), 32'd16);
    checkOutput("s2_drop_tail", 32'(alloc_rob_addr), 32'd0);
    pushRet(4'd0, 6'd20, 32'h100);
    pushRet(4'd1, 6'd21, 32'h101);
    applyStimulus(1'b0, 6'd0, 2'b01, 4'd0, 32'h100, 1'b0, 4'd0, 32'd0, 1'b0);
    checkOutput("s2_ret_head", 32'(ret_valid), 32'b01);
    checkOutput("s2_ready_while_full", 32'(alloc_ready), 32'd0);
    applyStimulus(1'b0, 6'd0, 2'b01, 4'd1, 32'h101, 1'b0, 4'd0, 32'd0, 1'b0);
    checkOutput("s2_count15", 32'(count), 32'd15);
    checkOutput("s2_ready_again", 32'(alloc_ready), 32'd1);
    checkOutput("s2_ret_second", 32'(ret_valid), 32'b01);
    allocOne(6'd40);
    checkOutput("s2_count_alloc_retire", 32'(count), 32'd15);
    checkOutput("s2_tail_after_wrap", 32'(alloc_rob_addr), 32'd1);
    checkOutput("s2_ret_stop", 32'(ret_valid), 32'd0);

    // Scenario 3: exception on entry 2; older entries retire first.
    doReset();
    for (int i = 0; i < 4; i++) allocOne(6'(30 + i));
    pushRet(4'd0, 6'd30, 32'hC0);
    pushRet(4'd1, 6'd31, 32'hC1);
    flushQ.push_back(4'd2);
    applyStimulus(1'b0, 6'd0, 2'b11, 4'd2, 32'hEE, 1'b1, 4'd3, 32'hC3, 1'b0);
    checkOutput("s3_wait_head", 32'(ret_valid), 32'd0);
    applyStimulus(1'b0, 6'd0, 2'b11, 4'd0, 32'hC0, 1'b0, 4'd1, 32'hC1, 1'b0);
    checkOutput("s3_ret_older", 32'(ret_valid), 32'b11);
    checkOutput("s3_no_flush_yet", 32'(flush), 32'd0);
    tick();
    checkOutput("s3_flush", 32'(flush), 32'd1);
    checkOutput("s3_flush_addr", 32'(flush_rob_addr), 32'd2);
    checkOutput("s3_flush_no_ret", 32'(ret_valid), 32'd0);
    tick();
    checkOutput("s3_flushing_count", 32'(count), 32'd0);
    checkOutput("s3_flushing_ready", 32'(alloc_ready), 32'd0);
    checkOutput("s3_flush_pulse_end", 32'(flush), 32'd0);
    applyStimulus(1'b1, 6'd5, 2'b01, 4'd0, 32'h77, 1'b0, 4'd0, 32'd0, 1'b0);
    checkOutput("s3_run_ready", 32'(alloc_ready), 32'd1);
    checkOutput("s3_run_count", 32'(count), 32'd0);
    checkOutput("s3_run_tail", 32'(alloc_rob_addr), 32'd0);
    tick();
    checkOutput("s3_ignored_traffic", 32'(ret_valid), 32'd0);

    // Scenario 4: both ports hit entry 5; port 1 must win.
    doReset();
    for (int i = 0; i < 6; i++) allocOne(6'(50 + i));
    for (int i = 0; i < 5; i++) pushRet(4'(i), 6'(50 + i), 32'h400 + 32'(i));
    pushRet(4'd5, 6'd55, 32'hBEEF);
    applyStimulus(1'b0, 6'd0, 2'b11, 4'd0, 32'h400, 1'b0, 4'd1, 32'h401, 1'b0);
    applyStimulus(1'b0, 6'd0, 2'b11, 4'd2, 32'h402, 1'b0, 4'd3, 32'h403, 1'b0);
    applyStimulus(1'b0, 6'd0, 2'b01, 4'd4, 32'h404, 1'b0, 4'd0, 32'd0, 1'b0);
    applyStimulus(1'b0, 6'd0, 2'b11, 4'd5, 32'hDEAD, 1'b0, 4'd5, 32'hBEEF, 1'b0);
    checkOutput("s4_port1_wins", ret_value[0], 32'hBEEF);
    tick();
    checkOutput("s4_drained", 32'(count), 32'd0);

    // Scenario 5: writeback to an unallocated index changes nothing.
    applyStimulus(1'b0, 6'd0, 2'b01, 4'd9, 32'h999, 1'b0, 4'd0, 32'd0, 1'b0);
    checkOutput("s5_count", 32'(count), 32'd0);
    checkOutput("s5_ret", 32'(ret_valid), 32'd0);
    checkOutput("s5_tail", 32'(alloc_rob_addr), 32'd6);
    tick();
    checkOutput("s5_ret_later", 32'(ret_valid), 32'd0);

    // Scenario 6: reset while in FLUSH.
    doReset();
    allocOne(6'd60);
    flushQ.push_back(4'd0);
    applyStimulus(1'b0, 6'd0, 2'b01, 4'd0, 32'h66, 1'b1, 4'd0, 32'd0, 1'b0);
    checkOutput("s6_flush", 32'(flush), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("s6_rst_ready", 32'(alloc_ready), 32'd0);
    checkOutput("s6_rst_flush", 32'(flush), 32'd0);
    checkOutput("s6_rst_ret", 32'(ret_valid), 32'd0);
    checkOutput("s6_rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("s6_after_ready", 32'(alloc_ready), 32'd1);
    checkOutput("s6_after_tail", 32'(alloc_rob_addr), 32'd0);

    tick();
    tick();
    checkOutput("retire_queue_drained", 32'(retQ.size()), 32'd0);
    checkOutput("flush_queue_drained", 32'(flushQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule
